// File: rtl/mdu_pkg.sv
// mdu_pkg: shared CPU definitions for the multiply/divide unit.
//   mdu_op_e    - op codes driven by the decoder onto mdu.op (codes 6-7 are no-ops)
//   mdu_state_e - MDU FSM encoding, also used by the pipeline stall logic
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the HI/LO registers.
// The full result is computed when a request is accepted and parked in
// pending registers; a counter models the latency and the result is
// committed to hi/lo on the edge that drops busy.
//   clk, reset  - clock, synchronous active-high reset
//   start, op   - one-cycle request and its op code (mdu_op_e)
//   a, b        - operands rs / rt (a is also MTHI/MTLO data)
//   busy        - mult/div in flight; start is ignored while high
//   hi, lo      - architectural HI / LO registers
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e  state_q, state_d;
    logic [31:0] cnt_q;
    logic        div_q;        // in-flight op is a divide (selects latency)
    logic        pend_ok_q;    // cleared for divide-by-zero: commit leaves hi/lo alone
    logic [31:0] pend_hi_q, pend_lo_q;
    logic [31:0] hi_q, lo_q;

    logic        accept, done, is_div, is_sdiv;
    logic [63:0] prod_s, prod_u;
    logic [31:0] mag_a, mag_b, q_mag, r_mag, quot, rem;
    logic [31:0] res_hi, res_lo;
    logic [31:0] lat;

    assign busy = (state_q == MDU_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        accept = 1'b0;
        if (state_q == MDU_IDLE && start) begin
            case (op)
                MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: accept = 1'b1;
                default:                                accept = 1'b0;
            endcase
        end
    end

    assign lat  = div_q ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
    assign done = (state_q == MDU_RUN) && (cnt_q == lat);

    always_ff @(posedge clk) begin
        if (reset) state_q <= MDU_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_IDLE: if (accept) state_d = MDU_RUN;
            MDU_RUN:  if (done)   state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
    end

    // Signed divide is done on magnitudes and the signs fixed afterwards,
    // so 0x80000000 / -1 never hits the host's signed-overflow case.
    always_comb begin
        is_div  = (op == MDU_DIV) || (op == MDU_DIVU);
        is_sdiv = (op == MDU_DIV);
        prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u  = {32'd0, a} * {32'd0, b};
        mag_a   = (is_sdiv && a[31]) ? (32'd0 - a) : a;
        mag_b   = (is_sdiv && b[31]) ? (32'd0 - b) : b;
        q_mag   = '0;
        r_mag   = '0;
        if (b != '0) begin
            q_mag = mag_a / mag_b;
            r_mag = mag_a % mag_b;
        end
        quot = (is_sdiv && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
        rem  = (is_sdiv && a[31])           ? (32'd0 - r_mag) : r_mag;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            default:   {res_hi, res_lo} = {rem, quot};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            div_q     <= 1'b0;
            pend_ok_q <= 1'b0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (state_q == MDU_RUN) begin
            if (done) begin
                cnt_q <= '0;
                if (pend_ok_q) begin
                    hi_q <= pend_hi_q;
                    lo_q <= pend_lo_q;
                end
            end else begin
                cnt_q <= cnt_q + 32'd1;
            end
        end else if (start) begin
            if (accept) begin
                cnt_q     <= 32'd1;
                div_q     <= is_div;
                pend_ok_q <= !(is_div && (b == '0));
                pend_hi_q <= res_hi;
                pend_lo_q <= res_lo;
            end else if (op == MDU_MTHI) begin
                hi_q <= a;
            end else if (op == MDU_MTLO) begin
                lo_q <= a;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed self-checking bench for mdu with hand-computed vectors.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue op, then count the cycles busy stays high (bounded).
    // Optionally inject an MTHI during busy cycle 2 and/or check hi/lo hold.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit inject, input bit chk_hold, output int n);
        logic [31:0] h0, l0;
        h0 = hi;
        l0 = lo;
        start = 1'b1; op = o; a = x; b = y;
        step();
        start = 1'b0; op = '0; a = '0; b = '0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (chk_hold && n == 3) begin
                check("hi_hold", 64'(hi), 64'(h0));
                check("lo_hold", 64'(lo), 64'(l0));
            end
            if (inject && n == 2) begin
                start = 1'b1; op = 3'(MDU_MTHI); a = 32'h0000_1234;
            end
            step();
            start = 1'b0; op = '0; a = '0;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        step();
        step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        reset = 1'b0;

        // MULT -2 * 3 = -6
        run_op(3'(MDU_MULT), 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1, n);
        check("mult_cycles", 64'(n),  64'd5);
        check("mult_hi",     64'(hi), 64'hFFFF_FFFF);
        check("mult_lo",     64'(lo), 64'hFFFF_FFFA);

        // MULTU 0xFFFFFFFF * 2
        run_op(3'(MDU_MULTU), 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, n);
        check("multu_cycles", 64'(n),  64'd5);
        check("multu_hi",     64'(hi), 64'h0000_0001);
        check("multu_lo",     64'(lo), 64'hFFFF_FFFE);

        // MULT -1 * -1 = 1
        run_op(3'(MDU_MULT), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, n);
        check("mult_nn_hi", 64'(hi), 64'h0);
        check("mult_nn_lo", 64'(lo), 64'h1);

        // DIV -7 / 2 = -3 rem -1, MTHI injected while busy must be ignored
        run_op(3'(MDU_DIV), 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, n);
        check("div_cycles", 64'(n),  64'd10);
        check("div_lo",     64'(lo), 64'hFFFF_FFFD);
        check("div_hi",     64'(hi), 64'hFFFF_FFFF);

        // DIV 7 / -2 = -3 rem 1
        run_op(3'(MDU_DIV), 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, n);
        check("div_pn_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_pn_hi", 64'(hi), 64'h1);

        // DIVU 100 / 7 = 14 rem 2
        run_op(3'(MDU_DIVU), 32'd100, 32'd7, 1'b0, 1'b0, n);
        check("divu_lo", 64'(lo), 64'd14);
        check("divu_hi", 64'(hi), 64'd2);

        // MTLO / MTHI with no busy cycle
        start = 1'b1; op = 3'(MDU_MTLO); a = 32'hA5A5_A5A5;
        step();
        start = 1'b0;
        check("mtlo_lo",   64'(lo),   64'hA5A5_A5A5);
        check("mtlo_busy", 64'(busy), 64'd0);
        check("mtlo_hi",   64'(hi),   64'd2);
        start = 1'b1; op = 3'(MDU_MTHI); a = 32'h0000_1111;
        step();
        start = 1'b0;
        check("mthi_hi",   64'(hi),   64'h1111);
        check("mthi_busy", 64'(busy), 64'd0);

        // DIVU by zero: full busy period, hi/lo untouched
        run_op(3'(MDU_DIVU), 32'd55, 32'd0, 1'b0, 1'b0, n);
        check("div0_cycles", 64'(n),  64'd10);
        check("div0_hi",     64'(hi), 64'h1111);
        check("div0_lo",     64'(lo), 64'hA5A5_A5A5);

        // op 6 is a no-op
        start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF; b = 32'd3;
        step();
        start = 1'b0;
        check("nop_busy", 64'(busy), 64'd0);
        check("nop_hi",   64'(hi),   64'h1111);
        check("nop_lo",   64'(lo),   64'hA5A5_A5A5);

        // Reset in busy cycle 3 aborts MULT 7*9 with no later commit
        start = 1'b1; op = 3'(MDU_MULT); a = 32'd7; b = 32'd9;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi",   64'(hi),   64'd0);
        check("abort_lo",   64'(lo),   64'd0);
        reset = 1'b0;
        repeat (12) step();
        check("abort_late_busy", 64'(busy), 64'd0);
        check("abort_late_lo",   64'(lo),   64'd0);

        // DIV overflow case
        run_op(3'(MDU_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, n);
        check("divovf_cycles", 64'(n),  64'd10);
        check("divovf_lo",     64'(lo), 64'h8000_0000);
        check("divovf_hi",     64'(hi), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
